ecc_apb_sequencer: RTL and testbench

- Upstream command sequencer for the ECC encoder/decoder block.
- Accepts one operation per valid/ready command: mode, codeword width, data and noise.
- Issues the matching APB write sequence into the ECC block's register file, then waits for operation_done.
- Returns data_out and num_of_errors on a valid/ready response channel, with timeout and illegal-command status.

---
 rtl/ecc_apb_sequencer.sv | 249 ++++++++++++++++++++++++
 tb/tb_ecc_apb_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_apb_sequencer.sv
`timescale 1ns / 1ps
// ecc_apb_sequencer
// Command sequencer for the ECC encoder/decoder block. It accepts one operation per
// cmd_valid/cmd_ready handshake. It then writes CODEWORD_WIDTH, DATA_IN, NOISE (full
// channel only) and CTRL over APB, in that order. After the writes it waits for
// operation_done. The result, or a timeout or illegal-command status, is returned on a
// rsp_valid/rsp_ready channel.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_mode, cmd_width            operation mode and codeword width (11 = illegal)
//   cmd_data, cmd_noise            DATA_IN and NOISE register values
//   PADDR/PWDATA/PSEL/PENABLE/PWRITE  registered APB write master (no PREADY)
//   operation_done, data_out, num_of_errors  completion interface from the ECC block
//   rsp_valid/rsp_ready            response handshake
//   rsp_data, rsp_errors, rsp_status  captured result; status 00 ok, 01 timeout, 10 illegal
//   busy                           high whenever the sequencer is not idle
module ecc_apb_sequencer #(
   parameter int AMBA_ADDR_WIDTH = 20,
   parameter int AMBA_WORD       = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int TIMEOUT_CYCLES  = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [1:0]                 cmd_mode,
   input  logic [1:0]                 cmd_width,
   input  logic [AMBA_WORD-1:0]       cmd_data,
   input  logic [AMBA_WORD-1:0]       cmd_noise,
   output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
   output logic [AMBA_WORD-1:0]       PWDATA,
   output logic                       PSEL,
   output logic                       PENABLE,
   output logic                       PWRITE,
   input  logic                       operation_done,
   input  logic [DATA_WIDTH-1:0]      data_out,
   input  logic [1:0]                 num_of_errors,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [DATA_WIDTH-1:0]      rsp_data,
   output logic [1:0]                 rsp_errors,
   output logic [1:0]                 rsp_status,
   output logic                       busy
);

   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StSetup  = 3'd1;
   localparam logic [2:0] StAccess = 3'd2;
   localparam logic [2:0] StWait   = 3'd3;
   localparam logic [2:0] StResp   = 3'd4;

   localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_CTRL  = AMBA_ADDR_WIDTH'(4'h0);
   localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_DATA  = AMBA_ADDR_WIDTH'(4'h4);
   localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_WIDTH = AMBA_ADDR_WIDTH'(4'h8);
   localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_NOISE = AMBA_ADDR_WIDTH'(4'hC);

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] STATUS_OK      = 2'b00;
   localparam logic [1:0] STATUS_TIMEOUT = 2'b01;
   localparam logic [1:0] STATUS_ILLEGAL = 2'b10;

   logic [2:0]                 state_q, state_d;
   logic [1:0]                 idx_q, idx_d;
   logic [1:0]                 mode_q, mode_d;
   logic [1:0]                 width_q, width_d;
   logic [AMBA_WORD-1:0]       data_q, data_d;
   logic [AMBA_WORD-1:0]       noise_q, noise_d;
   logic [7:0]                 cnt_q, cnt_d;
   logic [AMBA_ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic [AMBA_WORD-1:0]       pwdata_q, pwdata_d;
   logic                       psel_q, psel_d;
   logic                       penable_q, penable_d;
   logic                       pwrite_q, pwrite_d;
   logic [DATA_WIDTH-1:0]      rsp_data_q, rsp_data_d;
   logic [1:0]                 rsp_errors_q, rsp_errors_d;
   logic [1:0]                 rsp_status_q, rsp_status_d;

   // Address/data of the write that follows the current one (index 1..3). Index 0 is
   // always CODEWORD_WIDTH and is issued straight from the command inputs in IDLE.
   logic [1:0]                 nxt_idx;
   logic [1:0]                 last_idx;
   logic [AMBA_ADDR_WIDTH-1:0] wr_addr;
   logic [AMBA_WORD-1:0]       wr_data;

   always_comb begin
      nxt_idx  = idx_q + 2'd1;
      last_idx = (mode_q == 2'b10) ? 2'd3 : 2'd2;
      // CTRL is the default: it is always the final write.
      wr_addr  = ADDR_CTRL;
      wr_data  = {{(AMBA_WORD-2){1'b0}}, mode_q};
      case (nxt_idx)
         2'd1: begin
            wr_addr = ADDR_DATA;
            wr_data = data_q;
         end
         2'd2: begin
            if (mode_q == 2'b10) begin
               wr_addr = ADDR_NOISE;
               wr_data = noise_q;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      mode_d       = mode_q;
      width_d      = width_q;
      data_d       = data_q;
      noise_d      = noise_q;
      cnt_d        = cnt_q;
      paddr_d      = paddr_q;
      pwdata_d     = pwdata_q;
      psel_d       = psel_q;
      penable_d    = penable_q;
      pwrite_d     = pwrite_q;
      rsp_data_d   = rsp_data_q;
      rsp_errors_d = rsp_errors_q;
      rsp_status_d = rsp_status_q;

      case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               mode_d  = cmd_mode;
               width_d = cmd_width;
               data_d  = cmd_data;
               noise_d = cmd_noise;
               if ((cmd_mode == 2'b11) || (cmd_width == 2'b11)) begin
                  rsp_status_d = STATUS_ILLEGAL;
                  rsp_data_d   = '0;
                  rsp_errors_d = '0;
                  state_d      = StResp;
               end else begin
                  idx_d     = 2'd0;
                  psel_d    = 1'b1;
                  penable_d = 1'b0;
                  pwrite_d  = 1'b1;
                  paddr_d   = ADDR_WIDTH;
                  pwdata_d  = {{(AMBA_WORD-2){1'b0}}, cmd_width};
                  state_d   = StSetup;
               end
            end
         end
         StSetup: begin
            penable_d = 1'b1;
            state_d   = StAccess;
         end
         StAccess: begin
            if (idx_q != last_idx) begin
               idx_d     = nxt_idx;
               psel_d    = 1'b1;
               penable_d = 1'b0;
               pwrite_d  = 1'b1;
               paddr_d   = wr_addr;
               pwdata_d  = wr_data;
               state_d   = StSetup;
            end else begin
               psel_d    = 1'b0;
               penable_d = 1'b0;
               pwrite_d  = 1'b0;
               cnt_d     = '0;
               state_d   = StWait;
            end
         end
         StWait: begin
            // A done on the last counted cycle takes priority over the timeout.
            if (operation_done) begin
               rsp_data_d   = data_out;
               rsp_errors_d = num_of_errors;
               rsp_status_d = STATUS_OK;
               state_d      = StResp;
            end else if (cnt_q == CNT_LAST) begin
               rsp_data_d   = '0;
               rsp_errors_d = '0;
               rsp_status_d = STATUS_TIMEOUT;
               state_d      = StResp;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StResp: begin
            if (rsp_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            pwrite_d  = 1'b0;
            state_d   = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         idx_q        <= '0;
         mode_q       <= '0;
         width_q      <= '0;
         data_q       <= '0;
         noise_q      <= '0;
         cnt_q        <= '0;
         paddr_q      <= '0;
         pwdata_q     <= '0;
         psel_q       <= 1'b0;
         penable_q    <= 1'b0;
         pwrite_q     <= 1'b0;
         rsp_data_q   <= '0;
         rsp_errors_q <= '0;
         rsp_status_q <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         mode_q       <= mode_d;
         width_q      <= width_d;
         data_q       <= data_d;
         noise_q      <= noise_d;
         cnt_q        <= cnt_d;
         paddr_q      <= paddr_d;
         pwdata_q     <= pwdata_d;
         psel_q       <= psel_d;
         penable_q    <= penable_d;
         pwrite_q     <= pwrite_d;
         rsp_data_q   <= rsp_data_d;
         rsp_errors_q <= rsp_errors_d;
         rsp_status_q <= rsp_status_d;
      end
   end

   assign PADDR      = paddr_q;
   assign PWDATA     = pwdata_q;
   assign PSEL       = psel_q;
   assign PENABLE    = penable_q;
   assign PWRITE     = pwrite_q;
   assign cmd_ready  = (state_q == StIdle);
   assign rsp_valid  = (state_q == StResp);
   assign busy       = (state_q != StIdle);
   assign rsp_data   = rsp_data_q;
   assign rsp_errors = rsp_errors_q;
   assign rsp_status = rsp_status_q;

endmodule

// File: tb/tb_ecc_apb_sequencer.sv
`timescale 1ns / 1ps
// Self-checking bench for ecc_apb_sequencer: directed scenarios plus randomized commands,
// each checked against a transaction-level model of the expected APB writes, latency and
// response.
module tb_ecc_apb_sequencer;

   localparam int AW = 20;
   localparam int W  = 32;
   localparam int DW = 32;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [1:0]    cmd_mode = '0;
   logic [1:0]    cmd_width = '0;
   logic [W-1:0]  cmd_data = '0;
   logic [W-1:0]  cmd_noise = '0;
   logic [AW-1:0] PADDR;
   logic [W-1:0]  PWDATA;
   logic          PSEL, PENABLE, PWRITE;
   logic          operation_done = 1'b0;
   logic [DW-1:0] data_out = '0;
   logic [1:0]    num_of_errors = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [DW-1:0] rsp_data;
   logic [1:0]    rsp_errors, rsp_status;
   logic          busy;

   int tests = 0;
   int fails = 0;

   ecc_apb_sequencer #(
      .AMBA_ADDR_WIDTH(AW),
      .AMBA_WORD      (W),
      .DATA_WIDTH     (DW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_mode      (cmd_mode),
      .cmd_width     (cmd_width),
      .cmd_data      (cmd_data),
      .cmd_noise     (cmd_noise),
      .PADDR         (PADDR),
      .PWDATA        (PWDATA),
      .PSEL          (PSEL),
      .PENABLE       (PENABLE),
      .PWRITE        (PWRITE),
      .operation_done(operation_done),
      .data_out      (data_out),
      .num_of_errors (num_of_errors),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_data      (rsp_data),
      .rsp_errors    (rsp_errors),
      .rsp_status    (rsp_status),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Issue one command, act as the ECC block (done pulse d wait-cycles after the CTRL
   // access, d=0 never), compare against the model, then hold the response for `hold`
   // cycles with a stray done pulse before accepting it.
   task automatic run_cmd(input string tag, input logic [1:0] mode, input logic [1:0] width,
                          input logic [W-1:0] data, input logic [W-1:0] noise, input int d,
                          input logic [DW-1:0] dout, input logic [1:0] nerr, input int hold);
      logic [AW-1:0] exp_a[$];
      logic [W-1:0]  exp_w[$];
      logic [AW-1:0] obs_a[$];
      logic [W-1:0]  obs_w[$];
      logic [AW-1:0] setup_a;
      logic [W-1:0]  setup_w;
      logic          illegal;
      logic [DW-1:0] exp_data;
      logic [1:0]    exp_err, exp_status;
      int            exp_lat, n_wait, cyc, ctrl_cyc, lat;

      // Reference model: the register writes and the response follow directly from the
      // command fields.
      illegal = (mode == 2'b11) || (width == 2'b11);
      if (illegal) begin
         exp_lat    = 1;
         exp_status = 2'b10;
         exp_data   = '0;
         exp_err    = '0;
      end else begin
         exp_a.push_back(AW'(8'h08));
         exp_w.push_back(W'(width));
         exp_a.push_back(AW'(8'h04));
         exp_w.push_back(data);
         if (mode == 2'b10) begin
            exp_a.push_back(AW'(8'h0C));
            exp_w.push_back(noise);
         end
         exp_a.push_back(AW'(8'h00));
         exp_w.push_back(W'(mode));
         if (d >= 1 && d <= TO) begin
            n_wait     = d;
            exp_status = 2'b00;
            exp_data   = dout;
            exp_err    = nerr;
         end else begin
            n_wait     = TO;
            exp_status = 2'b01;
            exp_data   = '0;
            exp_err    = '0;
         end
         exp_lat = 1 + 2 * exp_a.size() + n_wait;
      end

      @(negedge clk);
      check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
      check({tag, "_idle_busy"}, 64'(busy), 64'd0);
      cmd_valid = 1'b1;
      cmd_mode  = mode;
      cmd_width = width;
      cmd_data  = data;
      cmd_noise = noise;
      @(posedge clk);

      cyc      = 0;
      ctrl_cyc = -1;
      lat      = -1;
      setup_a  = '0;
      setup_w  = '0;
      while (cyc < 100) begin
         @(negedge clk);
         cyc++;
         cmd_valid      = 1'b0;
         operation_done = 1'b0;
         if (rsp_valid) begin
            lat = cyc;
            break;
         end
         check({tag, "_busy"}, 64'(busy), 64'd1);
         check({tag, "_pwrite"}, 64'(PWRITE), 64'(PSEL));
         if (PSEL && !PENABLE) begin
            setup_a = PADDR;
            setup_w = PWDATA;
         end
         if (PENABLE) begin
            check({tag, "_acc_psel"}, 64'(PSEL), 64'd1);
            check({tag, "_acc_addr"}, 64'(PADDR), 64'(setup_a));
            check({tag, "_acc_data"}, 64'(PWDATA), 64'(setup_w));
            obs_a.push_back(PADDR);
            obs_w.push_back(PWDATA);
            if (PADDR == '0) ctrl_cyc = cyc;
         end
         if (ctrl_cyc > 0 && d > 0 && cyc == ctrl_cyc + d) begin
            operation_done = 1'b1;
            data_out       = dout;
            num_of_errors  = nerr;
         end
      end
      operation_done = 1'b0;

      check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      check({tag, "_nwrites"}, 64'(obs_a.size()), 64'(exp_a.size()));
      for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++) begin
         check($sformatf("%s_waddr%0d", tag, i), 64'(obs_a[i]), 64'(exp_a[i]));
         check($sformatf("%s_wdata%0d", tag, i), 64'(obs_w[i]), 64'(exp_w[i]));
      end
      check({tag, "_rsp_data"}, 64'(rsp_data), 64'(exp_data));
      check({tag, "_rsp_err"}, 64'(rsp_errors), 64'(exp_err));
      check({tag, "_rsp_status"}, 64'(rsp_status), 64'(exp_status));
      check({tag, "_rsp_cmd_ready"}, 64'(cmd_ready), 64'd0);

      for (int h = 0; h < hold; h++) begin
         operation_done = (h == 0);
         data_out       = ~dout;
         num_of_errors  = ~nerr;
         @(posedge clk);
         @(negedge clk);
         operation_done = 1'b0;
         check({tag, "_hold_valid"}, 64'(rsp_valid), 64'd1);
         check({tag, "_hold_data"}, 64'(rsp_data), 64'(exp_data));
         check({tag, "_hold_err"}, 64'(rsp_errors), 64'(exp_err));
         check({tag, "_hold_status"}, 64'(rsp_status), 64'(exp_status));
         check({tag, "_hold_cmd_ready"}, 64'(cmd_ready), 64'd0);
         check({tag, "_hold_psel"}, 64'(PSEL), 64'd0);
      end

      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      check({tag, "_post_valid"}, 64'(rsp_valid), 64'd0);
      check({tag, "_post_cmd_ready"}, 64'(cmd_ready), 64'd1);
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_paddr", 64'(PADDR), 64'd0);
      check("rst_pwdata", 64'(PWDATA), 64'd0);
      check("rst_psel", 64'(PSEL), 64'd0);
      check("rst_penable", 64'(PENABLE), 64'd0);
      check("rst_pwrite", 64'(PWRITE), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_rsp_data", 64'(rsp_data), 64'd0);
      check("rst_rsp_err", 64'(rsp_errors), 64'd0);
      check("rst_rsp_status", 64'(rsp_status), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_cmd_ready", 64'(cmd_ready), 64'd1);

      // Directed scenarios
      run_cmd("encode", 2'b00, 2'b00, 32'h0000_000B, 32'h0, 2, 32'hA5, 2'd0, 0);
      run_cmd("full", 2'b10, 2'b01, 32'h0000_07FF, 32'h0000_0003, 3, 32'h7FF, 2'd2, 0);
      run_cmd("illegal_mode", 2'b11, 2'b00, 32'h1234, 32'h0, 2, 32'h55, 2'd1, 0);
      run_cmd("illegal_width", 2'b01, 2'b11, 32'h1234, 32'h0, 2, 32'h55, 2'd1, 0);
      run_cmd("timeout", 2'b01, 2'b10, 32'hDEAD_BEEF, 32'h0, 0, 32'h77, 2'd1, 0);
      run_cmd("done_last", 2'b01, 2'b10, 32'hCAFE_0001, 32'h0, TO, 32'h99, 2'd3, 0);
      run_cmd("done_first", 2'b00, 2'b01, 32'h0000_1234, 32'h0, 1, 32'h4321, 2'd1, 0);
      run_cmd("backpressure", 2'b01, 2'b00, 32'h0000_00C3, 32'h0, 4, 32'h3C, 2'd1, 5);

      // Reset during the DATA_IN access cycle
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_mode  = 2'b10;
      cmd_width = 2'b10;
      cmd_data  = 32'h0BAD_F00D;
      cmd_noise = 32'h5;
      @(posedge clk);
      begin
         int  n;
         logic hit;
         n   = 0;
         hit = 1'b0;
         while (n < 20 && !hit) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            n++;
            hit = PSEL && PENABLE && (PADDR == AW'(8'h04));
         end
         check("midrst_found_access", 64'(hit), 64'd1);
      end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("midrst_psel", 64'(PSEL), 64'd0);
      check("midrst_penable", 64'(PENABLE), 64'd0);
      check("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
      run_cmd("after_rst", 2'b00, 2'b10, 32'h8000_0001, 32'h0, 2, 32'hFEED, 2'd1, 1);

      // Randomized commands
      for (int k = 0; k < 25; k++) begin
         run_cmd($sformatf("rand%0d", k), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 $urandom, $urandom, int'($urandom_range(0, TO + 2)), $urandom,
                 2'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
